// File: rtl/ysyx_pkg.sv
`default_nettype none
//============================================================================
// Module : ysyx_pkg
// Brief  : Shared encodings for the NPC core: data-memory read/write select
//          codes (also produced by the decoder) and the LSU state encoding.
// Rev    : 1.0  initial release
//============================================================================
package ysyx_pkg;

  // dm_rd_sel encodings; 3'b110 and 3'b111 are reserved
  localparam logic [2:0] DM_RD_NONE = 3'b000;
  localparam logic [2:0] DM_RD_LB   = 3'b001;
  localparam logic [2:0] DM_RD_LBU  = 3'b010;
  localparam logic [2:0] DM_RD_LH   = 3'b011;
  localparam logic [2:0] DM_RD_LHU  = 3'b100;
  localparam logic [2:0] DM_RD_LW   = 3'b101;

  // dm_wr_sel encodings
  localparam logic [1:0] DM_WR_NONE = 2'b00;
  localparam logic [1:0] DM_WR_SB   = 2'b01;
  localparam logic [1:0] DM_WR_SH   = 2'b10;
  localparam logic [1:0] DM_WR_SW   = 2'b11;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_e;

  // Halfword accesses need addr[0]==0, word accesses need addr[1:0]==0.
  function automatic logic lsu_misaligned(input logic [2:0] rd_sel,
                                          input logic [1:0] wr_sel,
                                          input logic [1:0] addr_lo);
    logic w_half;
    logic w_word;
    w_half = (rd_sel == DM_RD_LH) || (rd_sel == DM_RD_LHU) || (wr_sel == DM_WR_SH);
    w_word = (rd_sel == DM_RD_LW) || (wr_sel == DM_WR_SW);
    return (w_half && addr_lo[0]) || (w_word && (addr_lo != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_lsu_if.sv
`default_nettype none
//============================================================================
// Module : ysyx_lsu_req_if / ysyx_lsu_mem_if
// Brief  : Bundles for the LSU: execute/writeback side request-response
//          handshake, and the word-wide data-memory port.
// Rev    : 1.0  initial release
//============================================================================
interface ysyx_lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  dm_rd_sel;
  logic [1:0]  dm_wr_sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rdata;
  logic        rsp_err;

  // master: the core (EXU issues, WBU consumes)
  modport master (
    output req_valid, dm_rd_sel, dm_wr_sel, addr, wdata, rsp_ready,
    input  req_ready, rsp_valid, rdata, rsp_err
  );

  // slave: the LSU
  modport slave (
    input  req_valid, dm_rd_sel, dm_wr_sel, addr, wdata, rsp_ready,
    output req_ready, rsp_valid, rdata, rsp_err
  );
endinterface

interface ysyx_lsu_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  // master: the LSU
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  // slave: the data memory
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_lsu_align.sv
`default_nettype none
//============================================================================
// Module : ysyx_lsu_align
// Brief  : Combinational lane logic: store byte-enable/data replication and
//          load shift with sign/zero extension.
// Rev    : 1.0  initial release
//============================================================================
module ysyx_lsu_align
  import ysyx_pkg::*;
(
  input  logic [2:0]  i_rd_sel,
  input  logic [1:0]  i_wr_sel,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic        o_we,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata_lane,
  output logic [31:0] o_load_data
);

  logic [31:0] w_shifted;

  // Bring the addressed byte/halfword down to bit 0
  assign w_shifted = i_mem_rdata >> {i_addr_lo, 3'b000};

  // Store lanes: replicate the datum so every candidate lane carries it
  always_comb begin
    o_we         = 1'b0;
    o_wmask      = 4'b0000;
    o_wdata_lane = 32'h0000_0000;
    case (i_wr_sel)
      DM_WR_SB: begin
        o_we         = 1'b1;
        o_wmask      = 4'b0001 << i_addr_lo;
        o_wdata_lane = {4{i_wdata[7:0]}};
      end
      DM_WR_SH: begin
        o_we         = 1'b1;
        o_wmask      = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata_lane = {2{i_wdata[15:0]}};
      end
      DM_WR_SW: begin
        o_we         = 1'b1;
        o_wmask      = 4'b1111;
        o_wdata_lane = i_wdata;
      end
      default: begin
        // loads always fetch the whole word
        if (i_rd_sel != DM_RD_NONE) begin
          o_wmask = 4'b1111;
        end
      end
    endcase
  end

  // Load extension by access type
  always_comb begin
    o_load_data = 32'h0000_0000;
    case (i_rd_sel)
      DM_RD_LB:  o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      DM_RD_LBU: o_load_data = {24'h00_0000, w_shifted[7:0]};
      DM_RD_LH:  o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      DM_RD_LHU: o_load_data = {16'h0000, w_shifted[15:0]};
      DM_RD_LW:  o_load_data = w_shifted;
      default:   o_load_data = 32'h0000_0000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_lsu.sv
`default_nettype none
//============================================================================
// Module : ysyx_lsu
// Brief  : Load/store unit. One access at a time: decode/check in IDLE,
//          request the memory, wait for data/ack with a timeout, then hold
//          the extended result until the writeback stage takes it.
// Rev    : 1.0  initial release
//============================================================================
module ysyx_lsu
  import ysyx_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic           clk,
  input  logic           rst,
  ysyx_lsu_req_if.slave  req_bus,
  ysyx_lsu_mem_if.master mem_bus
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(MAX_WAIT);

  lsu_state_e       r_state;
  lsu_state_e       w_state_nxt;
  logic [2:0]       r_rd_sel;
  logic [1:0]       r_wr_sel;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_rdata;
  logic [31:0]      w_rdata_nxt;
  logic             r_rsp_err;
  logic             w_rsp_err_nxt;
  logic             w_accept;
  logic             w_req_none;
  logic             w_req_illegal;
  logic             w_req_misalign;
  logic             w_in_req;
  logic             w_in_resp;
  logic             w_timeout;
  logic             w_we;
  logic [3:0]       w_wmask;
  logic [31:0]      w_wdata_lane;
  logic [31:0]      w_load_data;

  assign w_req_none     = (req_bus.dm_rd_sel == DM_RD_NONE) && (req_bus.dm_wr_sel == DM_WR_NONE);
  assign w_req_illegal  = ((req_bus.dm_rd_sel != DM_RD_NONE) && (req_bus.dm_wr_sel != DM_WR_NONE))
                        || (req_bus.dm_rd_sel > DM_RD_LW);
  assign w_req_misalign = lsu_misaligned(req_bus.dm_rd_sel, req_bus.dm_wr_sel, req_bus.addr[1:0]);
  assign w_in_req       = (r_state == LSU_REQ);
  assign w_in_resp      = (r_state == LSU_RESP);
  assign w_timeout      = (r_cnt == C_CNT_MAX);

  // Lane logic works on the latched request so memory outputs stay stable
  ysyx_lsu_align u_align (
    .i_rd_sel     (r_rd_sel),
    .i_wr_sel     (r_wr_sel),
    .i_addr_lo    (r_addr[1:0]),
    .i_wdata      (r_wdata),
    .i_mem_rdata  (mem_bus.mem_rdata),
    .o_we         (w_we),
    .o_wmask      (w_wmask),
    .o_wdata_lane (w_wdata_lane),
    .o_load_data  (w_load_data)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LSU_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and the response value to capture on entry to RESP
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_rdata_nxt   = r_rdata;
    w_rsp_err_nxt = r_rsp_err;
    case (r_state)
      LSU_IDLE: begin
        if (req_bus.req_valid) begin
          w_accept      = 1'b1;
          w_rdata_nxt   = 32'h0000_0000;
          w_rsp_err_nxt = 1'b0;
          if (w_req_none) begin
            w_state_nxt = LSU_RESP;
          end else if (w_req_illegal || w_req_misalign) begin
            w_state_nxt   = LSU_RESP;
            w_rsp_err_nxt = 1'b1;
          end else begin
            w_state_nxt = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        // a grant in the last allowed cycle still wins over the timeout
        if (mem_bus.mem_gnt) begin
          w_state_nxt = LSU_WAIT;
        end else if (w_timeout) begin
          w_state_nxt   = LSU_RESP;
          w_rdata_nxt   = 32'h0000_0000;
          w_rsp_err_nxt = 1'b1;
        end
      end
      LSU_WAIT: begin
        if (mem_bus.mem_rvalid) begin
          w_state_nxt   = LSU_RESP;
          w_rdata_nxt   = w_load_data;
          w_rsp_err_nxt = 1'b0;
        end else if (w_timeout) begin
          w_state_nxt   = LSU_RESP;
          w_rdata_nxt   = 32'h0000_0000;
          w_rsp_err_nxt = 1'b1;
        end
      end
      LSU_RESP: begin
        if (req_bus.rsp_ready) begin
          w_state_nxt = LSU_IDLE;
        end
      end
      default: w_state_nxt = LSU_IDLE;
    endcase
  end

  // Request latches, timeout counter and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_sel  <= DM_RD_NONE;
      r_wr_sel  <= DM_WR_NONE;
      r_addr    <= 32'h0000_0000;
      r_wdata   <= 32'h0000_0000;
      r_cnt     <= '0;
      r_rdata   <= 32'h0000_0000;
      r_rsp_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rd_sel <= req_bus.dm_rd_sel;
        r_wr_sel <= req_bus.dm_wr_sel;
        r_addr   <= req_bus.addr;
        r_wdata  <= req_bus.wdata;
        r_cnt    <= '0;
      end else if (w_in_req || (r_state == LSU_WAIT)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_rdata   <= w_rdata_nxt;
      r_rsp_err <= w_rsp_err_nxt;
    end
  end

  // Outputs decoded from state and latched fields only
  assign req_bus.req_ready  = (r_state == LSU_IDLE);
  assign req_bus.rsp_valid  = w_in_resp;
  assign req_bus.rdata      = w_in_resp ? r_rdata : 32'h0000_0000;
  assign req_bus.rsp_err    = w_in_resp & r_rsp_err;

  assign mem_bus.mem_req    = w_in_req;
  assign mem_bus.mem_we     = w_in_req & w_we;
  assign mem_bus.mem_addr   = w_in_req ? {r_addr[31:2], 2'b00} : 32'h0000_0000;
  assign mem_bus.mem_wdata  = w_in_req ? w_wdata_lane : 32'h0000_0000;
  assign mem_bus.mem_wmask  = w_in_req ? w_wmask : 4'b0000;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_lsu.sv
`default_nettype none
//============================================================================
// Module : tb_ysyx_lsu
// Brief  : Directed bench for ysyx_lsu with a response scoreboard.
// Rev    : 1.0  initial release
//============================================================================
module tb_ysyx_lsu;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  exp_t q_main[$];
  exp_t q_t8[$];

  ysyx_lsu_req_if rb ();
  ysyx_lsu_mem_if mb ();
  ysyx_lsu_req_if rb8 ();
  ysyx_lsu_mem_if mb8 ();

  ysyx_lsu #(.MAX_WAIT(255)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_bus (rb.slave),
    .mem_bus (mb.master)
  );

  ysyx_lsu #(.MAX_WAIT(8)) dut8 (
    .clk     (clk),
    .rst     (rst),
    .req_bus (rb8.slave),
    .mem_bus (mb8.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Main DUT response monitor: compare every presented response to the queue head
  always @(negedge clk) begin
    if (!rst && rb.rsp_valid) begin
      if (q_main.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL main_rsp: unexpected response rdata=0x%08h err=%0b", rb.rdata, rb.rsp_err);
      end else begin
        chk("main_rdata", rb.rdata, q_main[0].rdata);
        chk("main_err", {31'd0, rb.rsp_err}, {31'd0, q_main[0].err});
        if (rb.rsp_ready) void'(q_main.pop_front());
      end
    end
  end

  // Short-timeout DUT response monitor
  always @(negedge clk) begin
    if (!rst && rb8.rsp_valid) begin
      if (q_t8.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL t8_rsp: unexpected response rdata=0x%08h err=%0b", rb8.rdata, rb8.rsp_err);
      end else begin
        chk("t8_rdata", rb8.rdata, q_t8[0].rdata);
        chk("t8_err", {31'd0, rb8.rsp_err}, {31'd0, q_t8[0].err});
        if (rb8.rsp_ready) void'(q_t8.pop_front());
      end
    end
  end

  task automatic chk_idle(input string name);
    chk({name, "_req_ready"}, {31'd0, rb.req_ready}, 32'd1);
    chk({name, "_rsp_valid"}, {31'd0, rb.rsp_valid}, 32'd0);
    chk({name, "_rsp_err"},   {31'd0, rb.rsp_err}, 32'd0);
    chk({name, "_rdata"},     rb.rdata, 32'd0);
    chk({name, "_mem_req"},   {31'd0, mb.mem_req}, 32'd0);
    chk({name, "_mem_we"},    {31'd0, mb.mem_we}, 32'd0);
    chk({name, "_mem_addr"},  mb.mem_addr, 32'd0);
    chk({name, "_mem_wdata"}, mb.mem_wdata, 32'd0);
    chk({name, "_mem_wmask"}, {28'd0, mb.mem_wmask}, 32'd0);
  endtask

  task automatic issue(input logic [2:0] rd, input logic [1:0] wr,
                       input logic [31:0] a, input logic [31:0] wd);
    rb.dm_rd_sel = rd;
    rb.dm_wr_sel = wr;
    rb.addr      = a;
    rb.wdata     = wd;
    rb.req_valid = 1'b1;
  endtask

  // Access with immediate grant and data the next cycle (minimum latency)
  task automatic run_fast(input string name, input logic [2:0] rd, input logic [1:0] wr,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mrd,
                          input logic [31:0] exp_rd, input logic exp_we, input logic [3:0] exp_mask,
                          input logic [31:0] exp_maddr, input logic [31:0] exp_mwd);
    q_main.push_back('{rdata: exp_rd, err: 1'b0});
    issue(rd, wr, a, wd);
    step();  // cycle 1
    rb.req_valid = 1'b0;
    chk({name, "_mem_req"},   {31'd0, mb.mem_req}, 32'd1);
    chk({name, "_mem_we"},    {31'd0, mb.mem_we}, {31'd0, exp_we});
    chk({name, "_mem_wmask"}, {28'd0, mb.mem_wmask}, {28'd0, exp_mask});
    chk({name, "_mem_addr"},  mb.mem_addr, exp_maddr);
    chk({name, "_mem_wdata"}, mb.mem_wdata, exp_mwd);
    mb.mem_gnt = 1'b1;
    step();  // cycle 2
    mb.mem_gnt    = 1'b0;
    mb.mem_rvalid = 1'b1;
    mb.mem_rdata  = mrd;
    chk({name, "_c2_mem_req"}, {31'd0, mb.mem_req}, 32'd0);
    chk({name, "_c2_rsp_valid"}, {31'd0, rb.rsp_valid}, 32'd0);
    step();  // cycle 3
    mb.mem_rvalid = 1'b0;
    chk({name, "_c3_rsp_valid"}, {31'd0, rb.rsp_valid}, 32'd1);
    step();
  endtask

  // Access rejected in IDLE: response next cycle, no memory request
  task automatic run_err(input string name, input logic [2:0] rd, input logic [1:0] wr,
                         input logic [31:0] a, input logic exp_err);
    q_main.push_back('{rdata: 32'd0, err: exp_err});
    issue(rd, wr, a, 32'hFFFF_FFFF);
    step();  // cycle 1
    rb.req_valid = 1'b0;
    chk({name, "_mem_req"},   {31'd0, mb.mem_req}, 32'd0);
    chk({name, "_rsp_valid"}, {31'd0, rb.rsp_valid}, 32'd1);
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    rb.req_valid  = 1'b0; rb.dm_rd_sel  = 3'd0; rb.dm_wr_sel  = 2'd0;
    rb.addr       = 32'd0; rb.wdata     = 32'd0; rb.rsp_ready  = 1'b1;
    mb.mem_gnt    = 1'b0; mb.mem_rvalid = 1'b0; mb.mem_rdata  = 32'd0;
    rb8.req_valid = 1'b0; rb8.dm_rd_sel = 3'd0; rb8.dm_wr_sel = 2'd0;
    rb8.addr      = 32'd0; rb8.wdata    = 32'd0; rb8.rsp_ready = 1'b1;
    mb8.mem_gnt   = 1'b0; mb8.mem_rvalid = 1'b0; mb8.mem_rdata = 32'd0;

    step();
    step();
    chk_idle("reset");
    rst = 1'b0;
    step();

    // loads/stores at minimum latency
    run_fast("lb",  3'b001, 2'b00, 32'h8000_0003, 32'h0,         32'h80AA_BBCC, 32'hFFFF_FF80, 1'b0, 4'b1111, 32'h8000_0000, 32'h0);
    run_fast("sh",  3'b000, 2'b10, 32'h8000_0002, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0,         1'b1, 4'b1100, 32'h8000_0000, 32'h5678_5678);
    run_fast("sb",  3'b000, 2'b01, 32'h8000_0001, 32'h0000_00AB, 32'h0,         32'h0,         1'b1, 4'b0010, 32'h8000_0000, 32'hABAB_ABAB);
    run_fast("sw",  3'b000, 2'b11, 32'h8000_0004, 32'hCAFE_BABE, 32'h0,         32'h0,         1'b1, 4'b1111, 32'h8000_0004, 32'hCAFE_BABE);
    run_fast("lw",  3'b101, 2'b00, 32'h8000_0008, 32'h0,         32'h1122_3344, 32'h1122_3344, 1'b0, 4'b1111, 32'h8000_0008, 32'h0);
    run_fast("lh",  3'b011, 2'b00, 32'h8000_0002, 32'h0,         32'h8001_1234, 32'hFFFF_8001, 1'b0, 4'b1111, 32'h8000_0000, 32'h0);
    run_fast("lbu", 3'b010, 2'b00, 32'h8000_0001, 32'h0,         32'h0000_F000, 32'h0000_00F0, 1'b0, 4'b1111, 32'h8000_0000, 32'h0);

    // rejected or empty accesses
    run_err("lw_mis",  3'b101, 2'b00, 32'h8000_0001, 1'b1);
    run_err("none",    3'b000, 2'b00, 32'h8000_0000, 1'b0);
    run_err("both",    3'b001, 2'b01, 32'h8000_0000, 1'b1);
    run_err("rsv6",    3'b110, 2'b00, 32'h8000_0000, 1'b1);
    run_err("sh_mis",  3'b000, 2'b10, 32'h8000_0003, 1'b1);

    // lhu with slow grant, slow data and a stalled writeback
    q_main.push_back('{rdata: 32'h0000_F00D, err: 1'b0});
    rb.rsp_ready = 1'b0;
    issue(3'b100, 2'b00, 32'h8000_0002, 32'h0);
    step();  // cycle 1
    rb.req_valid = 1'b0;
    repeat (4) step();  // cycle 5
    chk("lhu_c5_mem_req",  {31'd0, mb.mem_req}, 32'd1);
    chk("lhu_c5_mem_addr", mb.mem_addr, 32'h8000_0000);
    mb.mem_gnt = 1'b1;
    step();  // cycle 6
    mb.mem_gnt = 1'b0;
    chk("lhu_c6_mem_req", {31'd0, mb.mem_req}, 32'd0);
    repeat (5) step();  // cycle 11
    chk("lhu_c11_rsp_valid", {31'd0, rb.rsp_valid}, 32'd0);
    mb.mem_rvalid = 1'b1;
    mb.mem_rdata  = 32'hF00D_0000;
    step();  // cycle 12
    mb.mem_rvalid = 1'b0;
    mb.mem_rdata  = 32'h0;
    chk("lhu_c12_rsp_valid", {31'd0, rb.rsp_valid}, 32'd1);
    repeat (3) step();  // cycle 15
    rb.rsp_ready = 1'b1;
    step();
    chk("lhu_done_rsp_valid", {31'd0, rb.rsp_valid}, 32'd0);

    // timeout on the short-timeout instance, then a stray rvalid in IDLE
    q_t8.push_back('{rdata: 32'd0, err: 1'b1});
    rb8.dm_rd_sel = 3'b101;
    rb8.dm_wr_sel = 2'b00;
    rb8.addr      = 32'h8000_0010;
    rb8.req_valid = 1'b1;
    step();  // cycle 1
    rb8.req_valid = 1'b0;
    repeat (8) step();  // cycle 9
    chk("t8_c9_mem_req",   {31'd0, mb8.mem_req}, 32'd1);
    chk("t8_c9_rsp_valid", {31'd0, rb8.rsp_valid}, 32'd0);
    step();  // cycle 10
    chk("t8_c10_mem_req",   {31'd0, mb8.mem_req}, 32'd0);
    chk("t8_c10_rsp_valid", {31'd0, rb8.rsp_valid}, 32'd1);
    step();
    mb8.mem_rvalid = 1'b1;
    mb8.mem_rdata  = 32'h5555_AAAA;
    step();
    step();
    mb8.mem_rvalid = 1'b0;
    chk("t8_stray_rsp_valid", {31'd0, rb8.rsp_valid}, 32'd0);
    chk("t8_stray_req_ready", {31'd0, rb8.req_ready}, 32'd1);
    step();
    chk("t8_stray2_rsp_valid", {31'd0, rb8.rsp_valid}, 32'd0);

    // reset while waiting for data; a late rvalid must be ignored
    issue(3'b101, 2'b00, 32'h8000_0004, 32'h0);
    step();  // cycle 1
    rb.req_valid = 1'b0;
    mb.mem_gnt   = 1'b1;
    step();  // cycle 2, WAIT
    mb.mem_gnt = 1'b0;
    rst        = 1'b1;
    #1;
    chk_idle("rst_wait");
    mb.mem_rvalid = 1'b1;
    mb.mem_rdata  = 32'h0BAD_0BAD;
    step();
    rst = 1'b0;
    step();
    mb.mem_rvalid = 1'b0;
    chk("post_rst_rsp_valid", {31'd0, rb.rsp_valid}, 32'd0);
    chk("post_rst_req_ready", {31'd0, rb.req_ready}, 32'd1);
    run_fast("lw2", 3'b101, 2'b00, 32'h8000_0008, 32'h0, 32'h7654_3210, 32'h7654_3210, 1'b0, 4'b1111, 32'h8000_0008, 32'h0);

    step();
    chk("main_queue_left", 32'(q_main.size()), 32'd0);
    chk("t8_queue_left",   32'(q_t8.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_lsu.md
# ysyx_lsu

Load/store unit for the NPC core: executes the memory access requested by the decoder's `dm_rd_sel`/`dm_wr_sel` codes. Accepts one access per transaction from the execute stage, drives a variable-latency word-wide data-memory port with byte masks, and returns the sign- or zero-extended load result (or store acknowledge). Sits between EXU (address = ALU result, store data = rs2) and WBU (`rf_wr_sel = 2'b11` path).

## Interface
- `MAX_WAIT`, 255: cycles allowed in REQ+WAIT before the access is abandoned with error.
- `clk`  in  1  core clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_valid`  in  1  EXU presents an access.
- `req_ready`  out  1  LSU can accept (IDLE only).
- `dm_rd_sel`  in  3  000 none, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw.
- `dm_wr_sel`  in  2  00 none, 01 sb, 10 sh, 11 sw.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data (rs2).
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  WBU consumes result.
- `rdata`  out  32  extended load data; 0 for stores/errors.
- `rsp_err`  out  1  misaligned, illegal code combination, or timeout.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word-aligned address `{addr[31:2],2'b00}`.
- `mem_wdata`  out  32  lane-positioned store data.
- `mem_wmask`  out  4  byte enables.
- `mem_gnt`  in  1  request accepted.
- `mem_rvalid`  in  1  read data / write ack.
- `mem_rdata`  in  32  read word.

## Operation
- States IDLE, REQ, WAIT, RESP. Request fields (codes, addr, wdata) latched on accept.
- IDLE: `req_ready=1`. On `req_valid`:
  - both codes zero → RESP, `rdata=0`, `rsp_err=0`, no memory access.
  - both codes nonzero, or reserved `dm_rd_sel` (110/111) → RESP with `rsp_err=1`.
  - misaligned (half with `addr[0]=1`, word with `addr[1:0]!=0`) → RESP with `rsp_err=1`, no memory access.
  - otherwise → REQ.
- REQ: `mem_req=1`, address/data/mask/we stable until `mem_gnt`; on gnt → WAIT.
- WAIT: on `mem_rvalid` capture and extend → RESP, `rsp_err=0`.
- RESP: `rsp_valid=1`, `rdata`/`rsp_err` held stable until `rsp_ready`; then → IDLE.
- Store lanes: sb mask `4'b0001<<addr[1:0]`, data byte replicated ×4; sh mask `4'b0011<<{addr[1],1'b0}`, halfword replicated ×2; sw mask `4'b1111`. Loads: `mem_we=0`, mask `4'b1111`.
- Load extract: shift `mem_rdata` right by `8*addr[1:0]`; lb/lh sign-extend, lbu/lhu zero-extend, lw passthrough.
- Timeout: counter (`$clog2(MAX_WAIT+1)` bits) cleared on entering REQ, increments each cycle in REQ/WAIT. If it equals `MAX_WAIT` with no gnt (REQ) / rvalid (WAIT) that cycle → RESP with `rsp_err=1`, `rdata=0`. Completion in the same cycle wins over timeout.
- `mem_rvalid` outside WAIT is ignored. `mem_gnt` outside REQ is ignored.

## Timing
- Reset (async): state IDLE, counter 0, latched fields 0. `req_ready=1`; `rsp_valid`, `rsp_err`, `rdata`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wmask` all 0.
- Reset mid-transaction returns to IDLE immediately. Any outstanding memory response is dropped by the ignore rule.
- Minimum latency: accept at cycle 0, `mem_req` cycle 1 (gnt same cycle), `mem_rvalid` cycle 2, `rsp_valid` cycle 3.
- `mem_rvalid` is never in the same cycle as its `mem_gnt`.
- Error responses: `rsp_valid` at cycle 1.
- One outstanding access; no new accept before the RESP handshake completes. Back-to-back: accept possible the cycle after `rsp_ready`.
- All outputs registered or decoded from state/latched fields only; no input→output combinational path except none (`req_ready` depends on state only).

## Structure
- Shared package/defines `ysyx_pkg`: `dm_rd_sel`/`dm_wr_sel` encodings (shared with the decoder), LSU state encoding.
- One combinational sub-module `ysyx_lsu_align`: store lane/mask generation and load shift/extension. The FSM, timeout counter and latches stay in the top module.

## Test plan
- lb at `addr=0x8000_0003`, `mem_rdata=0x80AA_BBCC`, gnt immediate, rvalid next cycle → `rdata=0xFFFF_FF80`, `rsp_valid` at cycle 3, `rsp_err=0`.
- sh at `addr=0x8000_0002`, `wdata=0x1234_5678` → `mem_we=1`, `mem_addr=0x8000_0000`, `mem_wmask=4'b1100`, `mem_wdata=0x5678_5678`.
- lw at `addr=0x8000_0001` → no `mem_req`; `rsp_valid` at cycle 1 with `rsp_err=1`, `rdata=0`.
- lhu at `addr=0x8000_0002`, gnt delayed 4 cycles, rvalid 6 cycles later, `mem_rdata=0xF00D_0000` → `rdata=0x0000_F00D`; `rsp_ready` held low 3 cycles, `rdata` stable throughout.
- `MAX_WAIT=8`, gnt never asserted → `rsp_err=1` after 9 cycles in REQ, `mem_req` drops. A later stray `mem_rvalid` in IDLE produces no response.
- Reset asserted while in WAIT → outputs at reset values that cycle; next lw completes normally.
